// File: rtl/miner_job_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : miner_job_scheduler
// Brief    : Receives 20-word block-header jobs, starts the hasher array on
//            split nonce ranges and serialises results round-robin.
//            Optional early stop on first find: MINER_SCHED_EARLY_STOP_EN.
// Revision : 1.0 - initial release
//==============================================================================
module miner_job_scheduler #(
    parameter int          N_HASHERS    = 2,
    parameter logic [31:0] NONCE_STRIDE = 32'h0100_0000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [31:0]             s_tdata,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic [31:0]             m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    output logic [3:0]              m_tkeep,
    input  logic                    m_tready,
    output logic [607:0]            hashHeader,
    output logic [32*N_HASHERS-1:0] hashNonceBase,
    output logic [31:0]             hashNonceCount,
    output logic [N_HASHERS-1:0]    hashStart,
    output logic [N_HASHERS-1:0]    hashStop,
    input  logic [N_HASHERS-1:0]    hashDone,
    input  logic [N_HASHERS-1:0]    hashFound,
    input  logic [32*N_HASHERS-1:0] hashNonce,
    output logic                    busy,
    output logic [15:0]             jobCount
);

    localparam int         c_IW         = (N_HASHERS > 1) ? $clog2(N_HASHERS) : 1;
    localparam logic [1:0] c_ST_RECV    = 2'd0;
    localparam logic [1:0] c_ST_DISCARD = 2'd1;
    localparam logic [1:0] c_ST_START   = 2'd2;
    localparam logic [1:0] c_ST_RUN     = 2'd3;
    localparam logic [4:0] c_LAST_WORD  = 5'd19;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  r_s_tready;
    logic [4:0]            r_word_cnt;
    logic [607:0]          r_hdr_buf;
    logic [607:0]          r_header;
    logic [31:0]           r_start_nonce;
    logic [31:0]           r_nonce_base [N_HASHERS];
    logic [31:0]           w_nonce_in   [N_HASHERS];
    logic [N_HASHERS-1:0]  r_mask;
    logic [N_HASHERS-1:0]  r_pending;
    logic [N_HASHERS-1:0]  r_found;
    logic [31:0]           r_nonce      [N_HASHERS];
    logic [c_IW-1:0]       r_rr;
    logic [c_IW-1:0]       r_sel;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [31:0]           r_m_tdata;
    logic [15:0]           r_job_count;

    logic                  w_s_hs;
    logic                  w_start_load;
    logic                  w_job_done;
    logic                  w_out_free;
    logic                  w_load_pick;
    logic                  w_pick_vld;
    logic [c_IW-1:0]       w_pick_idx;
    logic [c_IW-1:0]       w_rr_next;
    logic [31:0]           w_start_nonce;
    logic [N_HASHERS-1:0]  w_cap;
    logic [N_HASHERS-1:0]  w_emit;
    logic [N_HASHERS-1:0]  w_clr;

    generate
        for (genvar gi = 0; gi < N_HASHERS; gi++) begin : g_lane
            assign hashNonceBase[gi*32 +: 32] = r_nonce_base[gi];
            assign w_nonce_in[gi]             = hashNonce[gi*32 +: 32];
        end
    endgenerate

    assign s_tready       = r_s_tready;
    assign m_tdata        = r_m_tdata;
    assign m_tvalid       = r_m_tvalid;
    assign m_tlast        = r_m_tlast;
    assign m_tkeep        = 4'hF;
    assign hashHeader     = r_header;
    assign hashNonceCount = NONCE_STRIDE;
    assign hashStart      = {N_HASHERS{r_state == c_ST_START}};
    assign busy           = (r_state != c_ST_RECV);
    assign jobCount       = r_job_count;

    assign w_s_hs        = s_tvalid && r_s_tready;
    assign w_start_load  = (w_next_state == c_ST_START) && (r_state != c_ST_START);
    assign w_start_nonce = (r_state == c_ST_RECV) ? s_tdata : r_start_nonce;
    assign w_cap         = {N_HASHERS{r_state == c_ST_RUN}} & hashDone & ~r_mask;
    assign w_out_free    = !r_m_tvalid || (m_tready && r_m_tlast);
    assign w_load_pick   = w_pick_vld && w_out_free;
    assign w_rr_next     = (w_pick_idx == c_IW'(N_HASHERS - 1)) ? '0 : w_pick_idx + 1'b1;
    assign w_job_done    = (r_state == c_ST_RUN) && (&r_mask) && (r_pending == '0) && w_out_free;

`ifdef MINER_SCHED_EARLY_STOP_EN
    logic r_stop_flag;

    // Once a find is captured, remaining non-finds are only acknowledged.
    assign w_emit   = w_cap & (hashFound | {N_HASHERS{~r_stop_flag}});
    assign hashStop = {N_HASHERS{r_stop_flag}} & ~r_mask;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stop_flag <= 1'b0;
        end else if (r_state == c_ST_START) begin
            r_stop_flag <= 1'b0;
        end else if (|(w_cap & hashFound)) begin
            r_stop_flag <= 1'b1;
        end
    end
`else
    assign w_emit   = w_cap;
    assign hashStop = '0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_RECV: begin
                if (w_s_hs && (r_word_cnt == c_LAST_WORD)) begin
                    w_next_state = s_tlast ? c_ST_START : c_ST_DISCARD;
                end
            end
            c_ST_DISCARD: begin
                if (w_s_hs && s_tlast) begin
                    w_next_state = c_ST_START;
                end
            end
            c_ST_START: w_next_state = c_ST_RUN;
            c_ST_RUN: begin
                if (w_job_done) begin
                    w_next_state = c_ST_RECV;
                end
            end
            default: w_next_state = c_ST_RECV;
        endcase
    end

    // Round-robin search: descending scan so the nearest index after r_rr wins.
    always_comb begin : p_arb
        int j;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        j          = 0;
        for (int k = N_HASHERS - 1; k >= 0; k--) begin
            j = int'(r_rr) + k;
            if (j >= N_HASHERS) begin
                j = j - N_HASHERS;
            end
            if (r_pending[j]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = c_IW'(j);
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_HASHERS; i++) begin
            w_clr[i] = w_load_pick && (w_pick_idx == c_IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= c_ST_RECV;
            r_s_tready    <= 1'b0;
            r_word_cnt    <= '0;
            r_hdr_buf     <= '0;
            r_header      <= '0;
            r_start_nonce <= '0;
            r_job_count   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_s_tready <= (w_next_state == c_ST_RECV) || (w_next_state == c_ST_DISCARD);
            if ((r_state == c_ST_RECV) && w_s_hs) begin
                if (r_word_cnt == c_LAST_WORD) begin
                    r_start_nonce <= s_tdata;
                    r_word_cnt    <= '0;
                end else begin
                    r_hdr_buf[{r_word_cnt, 5'd0} +: 32] <= s_tdata;
                    r_word_cnt <= s_tlast ? 5'd0 : r_word_cnt + 5'd1;
                end
            end
            // Hasher-facing header only changes at a job start.
            if (w_start_load) begin
                r_header <= r_hdr_buf;
            end
            if (w_job_done) begin
                r_job_count <= r_job_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_HASHERS; i++) begin
                r_nonce_base[i] <= '0;
            end
        end else if (w_start_load) begin
            for (int i = 0; i < N_HASHERS; i++) begin
                r_nonce_base[i] <= w_start_nonce + 32'(i) * NONCE_STRIDE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mask    <= '0;
            r_pending <= '0;
            r_found   <= '0;
            for (int i = 0; i < N_HASHERS; i++) begin
                r_nonce[i] <= '0;
            end
        end else begin
            if (r_state == c_ST_START) begin
                r_mask <= '0;
            end else begin
                r_mask <= r_mask | w_cap;
            end
            r_pending <= (r_pending | w_emit) & ~w_clr;
            for (int i = 0; i < N_HASHERS; i++) begin
                if (w_cap[i]) begin
                    r_found[i] <= hashFound[i];
                    r_nonce[i] <= w_nonce_in[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_sel      <= '0;
            r_rr       <= '0;
        end else begin
            if (r_m_tvalid && m_tready && !r_m_tlast) begin
                r_m_tdata <= r_nonce[r_sel];
                r_m_tlast <= 1'b1;
            end else if (w_load_pick) begin
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= 1'b0;
                r_m_tdata  <= {r_found[w_pick_idx], 15'd0, 16'(w_pick_idx)};
                r_sel      <= w_pick_idx;
                r_rr       <= w_rr_next;
            end else if (r_m_tvalid && m_tready) begin
                r_m_tvalid <= 1'b0;
                r_m_tlast  <= 1'b0;
                r_m_tdata  <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miner_job_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_miner_job_scheduler
// Brief    : Directed self-checking bench for miner_job_scheduler (N_HASHERS=2).
// Revision : 1.0 - initial release
//==============================================================================
module tb_miner_job_scheduler;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [31:0]     s_tdata = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tlast = 1'b0;
    logic            s_tready;
    logic [31:0]     m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic [3:0]      m_tkeep;
    logic            m_tready = 1'b0;
    logic [607:0]    hashHeader;
    logic [32*N-1:0] hashNonceBase;
    logic [31:0]     hashNonceCount;
    logic [N-1:0]    hashStart;
    logic [N-1:0]    hashStop;
    logic [N-1:0]    hashDone = '0;
    logic [N-1:0]    hashFound = '0;
    logic [32*N-1:0] hashNonce = '0;
    logic            busy;
    logic [15:0]     jobCount;

    int n_vec = 0;
    int n_err = 0;
    int n_starts = 0;
    int exp_jobs = 0;

    miner_job_scheduler #(.N_HASHERS(N), .NONCE_STRIDE(32'h0100_0000)) dut (
        .clk(clk), .rstn(rstn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tkeep(m_tkeep),
        .m_tready(m_tready),
        .hashHeader(hashHeader), .hashNonceBase(hashNonceBase), .hashNonceCount(hashNonceCount),
        .hashStart(hashStart), .hashStop(hashStop), .hashDone(hashDone), .hashFound(hashFound),
        .hashNonce(hashNonce), .busy(busy), .jobCount(jobCount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn && (hashStart != '0)) n_starts++;
    end

    task automatic send_job(input logic [31:0] base, input int nwords, input int last_idx,
                            input logic [31:0] w19);
        int t;
        for (int k = 0; k < nwords; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = (k == 19) ? w19 : base + 32'(k);
            s_tlast  = (k == last_idx);
            t = 0;
            while (!s_tready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) begin
                n_vec++; n_err++;
                $display("FAIL send_ready_timeout: beat %0d s_tready=%b required 1", k, s_tready);
            end
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] done, input logic [N-1:0] found,
                         input logic [31:0] n0, input logic [31:0] n1);
        hashDone  = done;
        hashFound = found;
        hashNonce = {n1, n0};
        @(negedge clk);
        hashDone  = '0;
        hashFound = '0;
    endtask

    task automatic get_beat(output logic [31:0] d, output logic l, output bit to);
        int t = 0;
        while (!(m_tvalid && m_tready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        to = (t >= 200);
        d  = m_tdata;
        l  = m_tlast;
        @(negedge clk);
    endtask

    task automatic wait_valid(output bit to);
        int t = 0;
        while (!m_tvalid && t < 100) begin
            @(negedge clk);
            t++;
        end
        to = (t >= 100);
    endtask

    task automatic wait_idle(output bit to);
        int t = 0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        to = (t >= 300);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({s_tready, m_tvalid, m_tlast, hashStart, hashStop, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required all zero",
                     {s_tready, m_tvalid, m_tlast, hashStart, hashStop, busy});
        end
        n_vec++;
        if (m_tdata !== 32'h0 || jobCount !== 16'h0) begin
            n_err++;
            $display("FAIL reset_data: m_tdata=%h jobCount=%h required 0", m_tdata, jobCount);
        end
        n_vec++;
        if (hashHeader !== '0 || hashNonceBase !== '0) begin
            n_err++;
            $display("FAIL reset_hash: header/base nonzero, base=%h", hashNonceBase);
        end
        n_vec++;
        if (m_tkeep !== 4'hF || hashNonceCount !== 32'h0100_0000) begin
            n_err++;
            $display("FAIL consts: tkeep=%h count=%h required F/01000000", m_tkeep, hashNonceCount);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (s_tready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b required 1", s_tready);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        logic [31:0] held;
        logic        l;
        bit          to;
        logic [31:0] ed [4];
        logic        el [4];
        ed = '{32'h8000_0000, 32'h1111_0000, 32'h0000_0001, 32'h2222_0000};
        el = '{1'b0, 1'b1, 1'b0, 1'b1};
        m_tready = 1'b0;
        send_job(32'hB000_0000, 20, 19, 32'h0000_1000);
        n_vec++;
        if (hashStart !== 2'b11) begin
            n_err++;
            $display("FAIL sim_start: got %b required 11", hashStart);
        end
        @(negedge clk);
        pulse(2'b11, 2'b01, 32'h1111_0000, 32'h2222_0000);
        wait_valid(to);
        n_vec++;
        if (to) begin
            n_err++;
            $display("FAIL sim_valid_timeout: m_tvalid=%b required 1", m_tvalid);
        end
        held = m_tdata;
        n_vec++;
        if (held !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL sim_first_word: got %h required 80000000", held);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b0, held}) begin
                n_err++;
                $display("FAIL sim_hold: cycle %0d valid=%b last=%b data=%h required 1/0/%h",
                         c, m_tvalid, m_tlast, m_tdata, held);
            end
        end
        m_tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            get_beat(d, l, to);
            n_vec++;
            if (to || d !== ed[b] || l !== el[b]) begin
                n_err++;
                $display("FAIL sim_beat%0d: data=%h last=%b timeout=%0d required %h/%b",
                         b, d, l, to, ed[b], el[b]);
            end
        end
        wait_idle(to);
        exp_jobs++;
        n_vec++;
        if (to || jobCount !== 16'(exp_jobs)) begin
            n_err++;
            $display("FAIL sim_jobcount: got %0d required %0d", jobCount, exp_jobs);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic        l;
        bit          to;
        logic [31:0] ed [4];
        logic        el [4];
        ed = '{32'h8000_0001, 32'h0000_1234, 32'h0000_0000, 32'hCAFE_0000};
        el = '{1'b0, 1'b1, 1'b0, 1'b1};
        m_tready = 1'b0;
        send_job(32'hA000_0000, 20, 19, 32'hFFFF_FF00);
        n_vec++;
        if (hashStart !== 2'b11) begin
            n_err++;
            $display("FAIL basic_start: got %b required 11", hashStart);
        end
        n_vec++;
        if (hashNonceBase !== {32'h00FF_FF00, 32'hFFFF_FF00}) begin
            n_err++;
            $display("FAIL basic_bases: got %h required 00ffff00ffffff00", hashNonceBase);
        end
        n_vec++;
        if (hashHeader[31:0] !== 32'hA000_0000 || hashHeader[607:576] !== 32'hA000_0012) begin
            n_err++;
            $display("FAIL basic_header: w0=%h w18=%h required a0000000/a0000012",
                     hashHeader[31:0], hashHeader[607:576]);
        end
        @(negedge clk);
        n_vec++;
        if (hashStart !== 2'b00 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_start_pulse: hashStart=%b busy=%b required 00/1", hashStart, busy);
        end
        pulse(2'b10, 2'b10, 32'h0, 32'h0000_1234);
        pulse(2'b01, 2'b00, 32'hCAFE_0000, 32'h0);
`ifndef MINER_SCHED_EARLY_STOP_EN
        n_vec++;
        if (hashStop !== 2'b00) begin
            n_err++;
            $display("FAIL basic_stop_tied: got %b required 00", hashStop);
        end
`endif
        m_tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            get_beat(d, l, to);
            n_vec++;
            if (to || d !== ed[b] || l !== el[b]) begin
                n_err++;
                $display("FAIL basic_beat%0d: data=%h last=%b timeout=%0d required %h/%b",
                         b, d, l, to, ed[b], el[b]);
            end
        end
        wait_idle(to);
        exp_jobs++;
        n_vec++;
        if (to || jobCount !== 16'(exp_jobs) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_end: jobCount=%0d busy=%b required %0d/0", jobCount, busy, exp_jobs);
        end
    endtask

    task automatic test_drop_discard();
        int  s0;
        bit  to;
        m_tready = 1'b1;
        s0 = n_starts;
        send_job(32'hC000_0000, 8, 7, 32'h0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (n_starts !== s0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drop_short: starts=%0d busy=%b required %0d/0", n_starts, busy, s0);
        end
        send_job(32'hD000_0000, 20, 19, 32'h0000_5000);
        n_vec++;
        if (hashStart !== 2'b11 || hashNonceBase !== {32'h0100_5000, 32'h0000_5000}) begin
            n_err++;
            $display("FAIL drop_next_start: start=%b bases=%h required 11/0100500000005000",
                     hashStart, hashNonceBase);
        end
        n_vec++;
        if (hashHeader[31:0] !== 32'hD000_0000 || hashHeader[607:576] !== 32'hD000_0012) begin
            n_err++;
            $display("FAIL drop_next_header: w0=%h w18=%h required d0000000/d0000012",
                     hashHeader[31:0], hashHeader[607:576]);
        end
        @(negedge clk);
        pulse(2'b11, 2'b00, 32'h1, 32'h2);
        wait_idle(to);
        exp_jobs++;
        n_vec++;
        if (to || jobCount !== 16'(exp_jobs)) begin
            n_err++;
            $display("FAIL drop_jobcount: got %0d required %0d", jobCount, exp_jobs);
        end
        s0 = n_starts;
        send_job(32'hE000_0000, 23, 22, 32'h0000_7000);
        n_vec++;
        if (hashStart !== 2'b11 || hashNonceBase !== {32'h0100_7000, 32'h0000_7000}) begin
            n_err++;
            $display("FAIL discard_start: start=%b bases=%h required 11/0100700000007000",
                     hashStart, hashNonceBase);
        end
        n_vec++;
        if (hashHeader[607:576] !== 32'hE000_0012) begin
            n_err++;
            $display("FAIL discard_header: w18=%h required e0000012", hashHeader[607:576]);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (n_starts !== s0 + 1) begin
            n_err++;
            $display("FAIL discard_one_start: starts=%0d required %0d", n_starts, s0 + 1);
        end
        pulse(2'b11, 2'b00, 32'h3, 32'h4);
        wait_idle(to);
        exp_jobs++;
        n_vec++;
        if (to || jobCount !== 16'(exp_jobs)) begin
            n_err++;
            $display("FAIL discard_jobcount: got %0d required %0d", jobCount, exp_jobs);
        end
    endtask

`ifdef MINER_SCHED_EARLY_STOP_EN
    task automatic test_early_stop();
        logic [31:0] d;
        logic        l;
        bit          to;
        int          extra;
        m_tready = 1'b0;
        send_job(32'hF000_0000, 20, 19, 32'h0);
        @(negedge clk);
        pulse(2'b01, 2'b01, 32'h0000_ABCD, 32'h0);
        repeat (2) @(negedge clk);
        n_vec++;
        if (hashStop !== 2'b10) begin
            n_err++;
            $display("FAIL es_stop: got %b required 10", hashStop);
        end
        pulse(2'b10, 2'b00, 32'h0, 32'h0000_9999);
        n_vec++;
        if (hashStop !== 2'b00) begin
            n_err++;
            $display("FAIL es_stop_release: got %b required 00", hashStop);
        end
        m_tready = 1'b1;
        get_beat(d, l, to);
        n_vec++;
        if (to || d !== 32'h8000_0000 || l !== 1'b0) begin
            n_err++;
            $display("FAIL es_word0: data=%h last=%b required 80000000/0", d, l);
        end
        get_beat(d, l, to);
        n_vec++;
        if (to || d !== 32'h0000_ABCD || l !== 1'b1) begin
            n_err++;
            $display("FAIL es_word1: data=%h last=%b required 0000abcd/1", d, l);
        end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_tvalid) extra++;
            @(negedge clk);
        end
        exp_jobs++;
        n_vec++;
        if (extra !== 0 || jobCount !== 16'(exp_jobs) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL es_single_packet: extra=%0d jobCount=%0d busy=%b required 0/%0d/0",
                     extra, jobCount, busy, exp_jobs);
        end
    endtask
`endif

    task automatic test_reset_in_run();
        bit to;
        int seen;
        m_tready = 1'b0;
        send_job(32'h1100_0000, 20, 19, 32'h0000_0042);
        @(negedge clk);
        pulse(2'b01, 2'b01, 32'h0000_0077, 32'h0);
        wait_valid(to);
        n_vec++;
        if (to) begin
            n_err++;
            $display("FAIL rir_valid_timeout: m_tvalid=%b required 1", m_tvalid);
        end
        rstn = 1'b0;
        #1;
        n_vec++;
        if ({s_tready, m_tvalid, m_tlast, hashStart, hashStop, busy} !== '0 ||
            m_tdata !== 32'h0 || jobCount !== 16'h0) begin
            n_err++;
            $display("FAIL rir_ctrl: ctrl=%b data=%h jobCount=%0d required zeros",
                     {s_tready, m_tvalid, m_tlast, hashStart, hashStop, busy}, m_tdata, jobCount);
        end
        n_vec++;
        if (hashHeader !== '0 || hashNonceBase !== '0) begin
            n_err++;
            $display("FAIL rir_hash: base=%h required 0 and header 0", hashNonceBase);
        end
        @(negedge clk);
        rstn = 1'b1;
        m_tready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_tvalid) seen++;
        end
        n_vec++;
        if (seen !== 0 || busy !== 1'b0 || jobCount !== 16'h0) begin
            n_err++;
            $display("FAIL rir_after: valid_cycles=%0d busy=%b jobCount=%0d required 0/0/0",
                     seen, busy, jobCount);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_basic();
        test_drop_discard();
`ifdef MINER_SCHED_EARLY_STOP_EN
        test_early_stop();
`endif
        test_reset_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
